mem_stage_lsu: RTL and testbench

Load/store unit for the MEM stage of the RV32IM pipeline. It sits between the EX/MEM pipeline register and the word-addressed data memory, and drives that memory's clk-synchronous word write and combinational word read.
- Converts byte/halfword/word loads and stores into word accesses.
- Stores narrower than a word use a read-modify-write sequence.
- Loads are sign- or zero-extended.
- Misaligned accesses are flagged without touching memory.
- Uses a valid/ready request handshake and a single-cycle response pulse; the pipeline stalls while req_ready is low.

---
 rtl/mem_pkg.sv | 19 +
 rtl/lsu_align.sv | 53 +++++
 rtl/mem_stage_lsu.sv | 127 ++++++++++++
 tb/tb_mem_stage_lsu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size codes,
// word-offset width and the LSU state type.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Byte-offset bits within a 32-bit word.
  localparam int unsigned WOFF_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: misalignment check on the incoming request,
// load lane extract with sign/zero extension, and store lane merge.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]        chk_size,
  input  logic [WOFF_W-1:0] chk_off,
  output logic              misalign,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [WOFF_W-1:0] off,
  input  logic [31:0]       rdata,
  input  logic [31:0]       wdata,
  output logic [31:0]       load_data,
  output logic [31:0]       merged
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;

  always_comb begin
    case (chk_size)
      SIZE_B:  misalign = 1'b0;
      SIZE_H:  misalign = chk_off[0];
      SIZE_W:  misalign = (chk_off != '0);
      default: misalign = 1'b1;
    endcase
  end

  // Halfword accesses are known aligned here, so off*8 is also the half shift.
  always_comb begin
    shamt     = {off, 3'b000};
    shifted   = rdata >> shamt;
    mask      = '0;
    load_data = rdata;
    merged    = wdata;
    case (size)
      SIZE_B: begin
        load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
        mask      = 32'h0000_00FF << shamt;
        merged    = (rdata & ~mask) | ((wdata & 32'h0000_00FF) << shamt);
      end
      SIZE_H: begin
        load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
        mask      = 32'h0000_FFFF << shamt;
        merged    = (rdata & ~mask) | ((wdata & 32'h0000_FFFF) << shamt);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns byte/half/word requests into word accesses
// on a word-addressed memory, using read-modify-write for sub-word stores.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misalign,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t        state, state_next;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, wbuf;
  logic              accept, req_mis;
  logic [DATA_W-1:0] load_data, merged;

  lsu_align u_align (
    .chk_size    (req_size),
    .chk_off     (req_addr[WOFF_W-1:0]),
    .misalign    (req_mis),
    .size        (size_q),
    .is_unsigned (uns_q),
    .off         (addr_q[WOFF_W-1:0]),
    .rdata       (mem_rdata),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  assign accept   = req_valid && (state == ST_IDLE);
  assign mem_addr = {addr_q[ADDR_W-1:WOFF_W], {WOFF_W{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_mis)                            state_next = ST_RESP;
          else if (req_we && req_size == SIZE_W)  state_next = ST_WRITE;
          else                                    state_next = ST_READ;
        end
      end
      ST_READ:  state_next = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE: begin
        mem_write  = 1'b1;
        mem_wdata  = wbuf;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Response registers are loaded on the edge entering RESP, so they hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wbuf          <= '0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          size_q  <= req_size;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          wbuf    <= req_wdata;
          if (req_mis) begin
            resp_rdata    <= '0;
            resp_misalign <= 1'b1;
          end
        end
        ST_READ: begin
          if (we_q) begin
            wbuf <= merged;
          end else begin
            resp_rdata    <= load_data;
            resp_misalign <= 1'b0;
          end
        end
        ST_WRITE: begin
          resp_rdata    <= '0;
          resp_misalign <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed table, reset cases, held-valid
// back-to-back loads and random traffic against a byte-array memory model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_misalign, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:15];
  logic        init_en = 1'b0;
  logic [3:0]  init_idx = '0;
  logic [31:0] init_val = '0;
  logic [7:0]  rb [0:63];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init_en)        mem[init_idx] <= init_val;
    else if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[5:2]];

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_misalign(resp_misalign), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic set_word(input int idx, input logic [31:0] val);
    @(negedge clk);
    init_en = 1'b1; init_idx = 4'(idx); init_val = val;
    @(posedge clk); #1;
    init_en = 1'b0;
    for (int b = 0; b < 4; b++) rb[idx*4+b] = 8'(val >> (8*b));
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {rb[idx*4+3], rb[idx*4+2], rb[idx*4+1], rb[idx*4]};
  endfunction

  // Reference: memory as bytes, accesses of n little-endian bytes.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic mis,
                       output int wcnt, output int wk, output logic [31:0] wword);
    int n;
    logic [31:0] v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis = (size == 2'd3) || (int'(addr) % n != 0);
    rdata = '0; wcnt = 0; wk = 0; wword = '0;
    if (mis) begin
      lat = 1;
    end else if (!we) begin
      lat = 2;
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(rb[int'(addr[5:0]) + i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rdata = v;
    end else begin
      for (int i = 0; i < n; i++) rb[int'(addr[5:0]) + i] = 8'(wdata >> (8*i));
      wcnt = 1;
      wk = (n == 4) ? 1 : 2;
      lat = wk + 1;
      wword = ref_word(int'(addr[5:2]));
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic mis,
                       output int wcnt, output int wk, output logic [31:0] waddr,
                       output logic [31:0] wword);
    lat = 0; rdata = '0; mis = 1'b0; wcnt = 0; wk = 0; waddr = '0; wword = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_write) begin wcnt++; wk = k; waddr = mem_addr; wword = mem_wdata; end
      if (resp_valid) begin lat = k; rdata = resp_rdata; mis = resp_misalign; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else passes++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else passes++;
    checks++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", resp_rdata); else passes++;
    checks++; if (resp_misalign !== 1'b0) $display("FAIL reset_misalign got %b want 0", resp_misalign); else passes++;
    checks++; if (mem_write !== 1'b0) $display("FAIL reset_mem_write got %b want 0", mem_write); else passes++;
    checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else passes++;
    checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); else passes++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) set_word(i, 32'h0);
    set_word(1, 32'h0000_0014);
  endtask

  typedef struct {
    logic we; logic [1:0] sz; logic u; logic [31:0] a; logic [31:0] wd;
    logic [31:0] rd; logic mis; int lat; int wc; logic [31:0] ww;
  } op_t;

  task automatic test_directed;
    op_t tbl [12];
    int lat, wcnt, wk, mlat, mwcnt, mwk;
    logic [31:0] rdata, waddr, wword, mrd, mww;
    logic mis, mmis;
    tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,        32'h0000_0014, 1'b0, 2, 0, 32'h0};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_00AB, 32'h0,         1'b0, 3, 1, 32'h0000_AB14};
    tbl[2]  = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,        32'h0000_AB14, 1'b0, 2, 0, 32'h0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h5, 32'h0,        32'hFFFF_FFAB, 1'b0, 2, 0, 32'h0};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h5, 32'h0,        32'h0000_00AB, 1'b0, 2, 0, 32'h0};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h4, 32'h0,        32'hFFFF_AB14, 1'b0, 2, 0, 32'h0};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h6, 32'h0000_1234, 32'h0,         1'b0, 3, 1, 32'h1234_AB14};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,        32'h1234_AB14, 1'b0, 2, 0, 32'h0};
    tbl[8]  = '{1'b1, 2'd1, 1'b0, 32'h3, 32'h0000_5555, 32'h0,         1'b1, 1, 0, 32'h0};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h2, 32'h0,        32'h0,         1'b1, 1, 0, 32'h0};
    tbl[10] = '{1'b1, 2'd3, 1'b0, 32'h4, 32'hFFFF_FFFF, 32'h0,         1'b1, 1, 0, 32'h0};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 32'hC, 32'hCAFE_F00D, 32'h0,         1'b0, 2, 1, 32'hCAFE_F00D};
    for (int i = 0; i < 12; i++) begin
      model(tbl[i].we, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, mlat, mrd, mmis, mwcnt, mwk, mww);
      issue(tbl[i].we, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, lat, rdata, mis, wcnt, wk, waddr, wword);
      checks++; if (lat !== tbl[i].lat) $display("FAIL dir_lat[%0d] got %0d want %0d", i, lat, tbl[i].lat); else passes++;
      checks++; if (rdata !== tbl[i].rd) $display("FAIL dir_rdata[%0d] got %h want %h", i, rdata, tbl[i].rd); else passes++;
      checks++; if (mis !== tbl[i].mis) $display("FAIL dir_misalign[%0d] got %b want %b", i, mis, tbl[i].mis); else passes++;
      checks++; if (wcnt !== tbl[i].wc) $display("FAIL dir_wcount[%0d] got %0d want %0d", i, wcnt, tbl[i].wc); else passes++;
      if (tbl[i].wc != 0) begin
        checks++; if (wk !== tbl[i].lat - 1) $display("FAIL dir_wcycle[%0d] got %0d want %0d", i, wk, tbl[i].lat - 1); else passes++;
        checks++; if (waddr !== {tbl[i].a[31:2], 2'b00}) $display("FAIL dir_waddr[%0d] got %h want %h", i, waddr, {tbl[i].a[31:2], 2'b00}); else passes++;
        checks++; if (wword !== tbl[i].ww) $display("FAIL dir_wdata[%0d] got %h want %h", i, wword, tbl[i].ww); else passes++;
      end
    end
    checks++; if (mem[1] !== 32'h1234_AB14) $display("FAIL dir_word1 got %h want 1234ab14", mem[1]); else passes++;
    checks++; if (mem[0] !== 32'h0) $display("FAIL dir_word0 got %h want 0", mem[0]); else passes++;
  endtask

  task automatic test_reset_mid_write;
    set_word(2, 32'h1111_1111);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h8; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (mem_write !== 1'b1) $display("FAIL rmw_write_before got %b want 1", mem_write); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0) $display("FAIL rmw_write_drop got %b want 0", mem_write); else passes++;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL rmw_ready got %b want 1", req_ready); else passes++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL rmw_resp_valid got %b want 0", resp_valid); else passes++;
    checks++; if (mem[2] !== 32'h1111_1111) $display("FAIL rmw_word2 got %h want 11111111", mem[2]); else passes++;
  endtask

  task automatic test_back_to_back;
    int accepts [$];
    int pulses;
    logic ready_s;
    logic [31:0] exp;
    exp = ref_word(1);
    pulses = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h4;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      ready_s = req_ready;
      if (i == 1 || i == 2) begin
        checks++; if (ready_s !== 1'b0) $display("FAIL b2b_ready_busy[%0d] got %b want 0", i, ready_s); else passes++;
      end
      @(posedge clk);
      if (ready_s && req_valid) accepts.push_back(i);
      #1;
      if (i == 3) req_valid = 1'b0;
      if (resp_valid) begin
        pulses++;
        checks++; if (resp_rdata !== exp) $display("FAIL b2b_rdata got %h want %h", resp_rdata, exp); else passes++;
      end
    end
    checks++; if (accepts.size() !== 2) $display("FAIL b2b_accepts got %0d want 2", accepts.size()); else passes++;
    if (accepts.size() == 2) begin
      checks++; if (accepts[1] - accepts[0] !== 3) $display("FAIL b2b_gap got %0d want 3", accepts[1] - accepts[0]); else passes++;
    end
    checks++; if (pulses !== 2) $display("FAIL b2b_pulses got %0d want 2", pulses); else passes++;
  endtask

  task automatic test_random;
    int lat, wcnt, wk, mlat, mwcnt, mwk;
    logic [31:0] rdata, waddr, wword, mrd, mww, a, wd;
    logic mis, mmis, we, u;
    logic [1:0] sz;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3)); a = 32'($urandom_range(0, 63)); wd = $urandom;
      model(we, sz, u, a, wd, mlat, mrd, mmis, mwcnt, mwk, mww);
      issue(we, sz, u, a, wd, lat, rdata, mis, wcnt, wk, waddr, wword);
      checks++; if (lat !== mlat || rdata !== mrd || mis !== mmis)
        $display("FAIL rnd_resp[%0d] got lat=%0d rd=%h mis=%b want lat=%0d rd=%h mis=%b", i, lat, rdata, mis, mlat, mrd, mmis);
      else passes++;
      checks++; if (wcnt !== mwcnt || wk !== mwk || wword !== mww || (mwcnt != 0 && waddr !== {a[31:2], 2'b00}))
        $display("FAIL rnd_write[%0d] got n=%0d k=%0d a=%h d=%h want n=%0d k=%0d d=%h", i, wcnt, wk, waddr, wword, mwcnt, mwk, mww);
      else passes++;
    end
    for (int w = 0; w < 16; w++) begin
      checks++; if (mem[w] !== ref_word(w)) $display("FAIL rnd_mem[%0d] got %h want %h", w, mem[w], ref_word(w)); else passes++;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_reset_mid_write;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
